// File: rtl/radix_seg_display_if.sv
// Conversion handshake bundle for radix_seg_display.
// The requester (master) presents start/din/mode. The converter (slave)
// reports busy, a one-cycle done pulse and the overflow status.
interface radix_seg_display_if #(
    parameter int IN_W = 16
);
    logic            start;
    logic [IN_W-1:0] din;
    logic [1:0]      mode;
    logic            busy;
    logic            done;
    logic            ovf;

    modport master (
        output start, din, mode,
        input  busy, done, ovf
    );

    modport slave (
        input  start, din, mode,
        output busy, done, ovf
    );
endinterface

// File: rtl/radix_seg_display.sv
// Binary to octal/decimal/hex converter with a multiplexed 7-segment driver.
// A generalised shift-add engine converts one input bit per cycle, MSB first.
// It commits a result register. A free-running scanner then shows that
// result one digit at a time, with optional leading-zero blanking and an
// overflow indication.
module radix_seg_display #(
    parameter int IN_W     = 16,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                clk,
    input  logic                rst,
    radix_seg_display_if.slave  bus,
    input  logic                blank_lz,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   dig_sel
);

    localparam int AW = DIGITS * 4;
    localparam int BW = $clog2(IN_W);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;

    // Reject parameter values outside the supported ranges at elaboration.
    if (IN_W < 4 || IN_W > 32) begin : g_bad_in_w
        $error("radix_seg_display: IN_W must be in 4..32");
    end
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("radix_seg_display: DIGITS must be in 1..8");
    end
    if (SCAN_DIV < 1) begin : g_bad_scan_div
        $error("radix_seg_display: SCAN_DIV must be >= 1");
    end

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t          state;
    logic [IN_W-1:0] din_q;
    logic [1:0]      mode_q;
    logic [BW-1:0]   bit_cnt;
    logic [AW-1:0]   acc;
    logic            acc_ovf;
    logic [AW-1:0]   result;
    logic            result_valid;
    logic            busy_r;
    logic            done_r;
    logic            ovf_r;

    logic [AW-1:0]   acc_adj;
    logic [AW-1:0]   acc_next;
    logic            ovf_next;

    logic [SW-1:0]   scan_cnt;
    logic [IW-1:0]   digit_idx;
    logic [IW-1:0]   next_idx;
    logic [DIGITS-1:0] lead_zero;
    logic [6:0]      glyph_all [DIGITS];
    logic [6:0]      next_seg;

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.ovf  = ovf_r;

    // Hex digit value to segment pattern, bit6..bit0 = a..g.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0:    g = 7'b1111110;
            4'h1:    g = 7'b0110000;
            4'h2:    g = 7'b1101101;
            4'h3:    g = 7'b1111001;
            4'h4:    g = 7'b0110011;
            4'h5:    g = 7'b1011011;
            4'h6:    g = 7'b1011111;
            4'h7:    g = 7'b1110000;
            4'h8:    g = 7'b1111111;
            4'h9:    g = 7'b1111011;
            4'hA:    g = 7'b1110111;
            4'hB:    g = 7'b0011111;
            4'hC:    g = 7'b1001110;
            4'hD:    g = 7'b0111101;
            4'hE:    g = 7'b1001111;
            default: g = 7'b1000111;
        endcase
        return g;
    endfunction

    // One shift-add step.
    // First add the per-radix correction to every digit that will carry
    // when doubled. Then shift the next din bit in at digit0. The bit that
    // leaves the top digit is the overflow.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            case (mode_q)
                2'b00: begin
                    if (acc[i*4 +: 4] >= 4'd4)
                        acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd4;
                end
                2'b01: begin
                    if (acc[i*4 +: 4] >= 4'd5)
                        acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
                end
                default: begin
                end
            endcase
        end
        acc_next = {acc_adj[AW-2:0], din_q[IN_W-1]};
        ovf_next = acc_ovf | acc_adj[AW-1];
    end

    // Conversion FSM.
    // It latches operands on an accepted start and runs IN_W steps. On the
    // final step it commits the result, drops busy and pulses done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            din_q        <= '0;
            mode_q       <= 2'b00;
            bit_cnt      <= '0;
            acc          <= '0;
            acc_ovf      <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            ovf_r        <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        din_q   <= bus.din;
                        mode_q  <= bus.mode;
                        acc     <= '0;
                        acc_ovf <= 1'b0;
                        bit_cnt <= '0;
                        busy_r  <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    acc     <= acc_next;
                    acc_ovf <= ovf_next;
                    din_q   <= {din_q[IN_W-2:0], 1'b0};
                    bit_cnt <= bit_cnt + BW'(1);
                    if (bit_cnt == BW'(IN_W - 1)) begin
                        result       <= acc_next;
                        ovf_r        <= ovf_next;
                        result_valid <= 1'b1;
                        busy_r       <= 1'b0;
                        done_r       <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Mark digits above the most significant nonzero digit. Digit0 is never marked.
    always_comb begin
        logic run;
        run       = 1'b1;
        lead_zero = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run          = run & (result[i*4 +: 4] == 4'd0);
            lead_zero[i] = run & (i != 0);
        end
    end

    // Pick the pattern each digit would show.
    // The priority is: nothing committed yet, then overflow, then
    // leading-zero blanking, then the glyph.
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            if (!result_valid)
                glyph_all[i] = SEG_BLANK;
            else if (ovf_r)
                glyph_all[i] = SEG_DASH;
            else if (blank_lz && lead_zero[i])
                glyph_all[i] = SEG_BLANK;
            else
                glyph_all[i] = glyph(result[i*4 +: 4]);
        end
    end

    // Work out the next digit in scan order and its pattern.
    always_comb begin
        next_idx = (digit_idx == IW'(DIGITS - 1)) ? '0 : digit_idx + IW'(1);
        next_seg = SEG_BLANK;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == next_idx)
                next_seg = glyph_all[i];
        end
    end

    // Free-running scanner.
    // It moves to the next digit every SCAN_DIV cycles. dig_sel and seg
    // update together on that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
            dig_sel   <= DIGITS'(1);
            seg       <= SEG_BLANK;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt  <= '0;
            digit_idx <= next_idx;
            dig_sel   <= DIGITS'(1) << next_idx;
            seg       <= next_seg;
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

endmodule

// File: tb/tb_radix_seg_display.sv
// Directed, table-driven bench for radix_seg_display.
// It uses IN_W=16, DIGITS=4 and SCAN_DIV=4. Expected segment patterns
// are hand-computed constants.
module tb_radix_seg_display;

    localparam logic [6:0] G0 = 7'b1111110, G1 = 7'b0110000, G2 = 7'b1101101;
    localparam logic [6:0] G3 = 7'b1111001, G4 = 7'b0110011, G5 = 7'b1011011;
    localparam logic [6:0] G6 = 7'b1011111, G7 = 7'b1110000, G8 = 7'b1111111;
    localparam logic [6:0] GA = 7'b1110111, GB = 7'b0011111;
    localparam logic [6:0] GC = 7'b1001110, GD = 7'b0111101, GE = 7'b1001111;
    localparam logic [6:0] GF = 7'b1000111, BL = 7'b0000000, DS = 7'b0000001;

    typedef struct {
        string       name;
        logic [15:0] din;
        logic [1:0]  mode;
        logic        blz;
        logic [27:0] exp_seg;
        logic        exp_ovf;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       blank_lz;
    logic [6:0] seg;
    logic [3:0] dig_sel;

    int total;
    int bad;

    vec_t vecs[13];

    radix_seg_display_if #(.IN_W(16)) bus ();

    radix_seg_display #(
        .IN_W(16),
        .DIGITS(4),
        .SCAN_DIV(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .blank_lz(blank_lz),
        .seg(seg),
        .dig_sel(dig_sel)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value against its expected value and count the result.
    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Issue start with the given operands, optionally pulsing a second start mid-conversion.
    // Returns at the negedge where done should be high.
    task automatic applyStimulus(input logic [15:0] d, input logic [1:0] m,
                                 input int glitch_at, input bit immediate);
        int busy_cycles;
        int early_done;
        if (!immediate) @(negedge clk);
        bus.start = 1'b1;
        bus.din   = d;
        bus.mode  = m;
        @(negedge clk);
        bus.start = 1'b0;
        bus.din   = ~d;
        bus.mode  = ~m;
        busy_cycles = 0;
        early_done  = 0;
        while (bus.busy === 1'b1 && busy_cycles < 40) begin
            busy_cycles++;
            if (bus.done !== 1'b0) early_done++;
            if (busy_cycles == glitch_at) begin
                bus.start = 1'b1;
                bus.din   = 16'd9;
                bus.mode  = 2'b00;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        checkOutput("busy_cycles", busy_cycles, 16);
        checkOutput("done_early", early_done, 0);
        checkOutput("done_rise", {31'd0, bus.done}, 1);
    endtask

    // Let every digit refresh, then collect one full scan and compare each digit.
    task automatic checkDisplay(input logic [27:0] exp, input string name);
        logic [6:0] got [4];
        logic [3:0] seen;
        seen = 4'h0;
        for (int i = 0; i < 4; i++) got[i] = 7'h7f;
        repeat (20) @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (dig_sel === 4'(1 << i)) begin
                    got[i]  = seg;
                    seen[i] = 1'b1;
                end
            end
            @(negedge clk);
        end
        checkOutput({name, "_seen"}, {28'd0, seen}, 32'hF);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("%s_d%0d", name, i), {25'd0, got[i]}, {25'd0, exp[i*7 +: 7]});
    endtask

    // Main sequence: reset checks, vector table, then multi-cycle corner cases.
    initial begin
        int stay;
        total = 0;
        bad   = 0;

        vecs[0]  = '{"dec1234",  16'd1234,  2'b01, 1'b1, {G1, G2, G3, G4}, 1'b0};
        vecs[1]  = '{"oct9",     16'd9,     2'b00, 1'b1, {BL, BL, G1, G1}, 1'b0};
        vecs[2]  = '{"oct9_lz0", 16'd9,     2'b00, 1'b0, {G0, G0, G1, G1}, 1'b0};
        vecs[3]  = '{"hexbeef",  16'hBEEF,  2'b10, 1'b1, {GB, GE, GE, GF}, 1'b0};
        vecs[4]  = '{"dec65535", 16'd65535, 2'b01, 1'b1, {DS, DS, DS, DS}, 1'b1};
        vecs[5]  = '{"oct7",     16'd7,     2'b00, 1'b1, {BL, BL, BL, G7}, 1'b0};
        vecs[6]  = '{"dec0",     16'd0,     2'b01, 1'b1, {BL, BL, BL, G0}, 1'b0};
        vecs[7]  = '{"hex00a5",  16'h00A5,  2'b10, 1'b0, {G0, G0, GA, G5}, 1'b0};
        vecs[8]  = '{"m11_1c3d", 16'h1C3D,  2'b11, 1'b1, {G1, GC, G3, GD}, 1'b0};
        vecs[9]  = '{"dec8765",  16'd8765,  2'b01, 1'b1, {G8, G7, G6, G5}, 1'b0};
        vecs[10] = '{"dec10000", 16'd10000, 2'b01, 1'b1, {DS, DS, DS, DS}, 1'b1};
        vecs[11] = '{"oct4095",  16'd4095,  2'b00, 1'b1, {G7, G7, G7, G7}, 1'b0};
        vecs[12] = '{"hex0100",  16'h0100,  2'b10, 1'b1, {BL, G1, G0, G0}, 1'b0};

        rst       = 1'b1;
        blank_lz  = 1'b1;
        bus.start = 1'b0;
        bus.din   = '0;
        bus.mode  = 2'b00;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", {31'd0, bus.busy}, 0);
        checkOutput("rst_done", {31'd0, bus.done}, 0);
        checkOutput("rst_ovf", {31'd0, bus.ovf}, 0);
        checkOutput("rst_seg", {25'd0, seg}, 0);
        checkOutput("rst_dig_sel", {28'd0, dig_sel}, 1);
        rst = 1'b0;

        stay = 0;
        while (dig_sel === 4'b0001 && stay < 20) begin
            stay++;
            @(negedge clk);
        end
        checkOutput("scan_first_hold", stay, 4);
        checkOutput("scan_step1", {28'd0, dig_sel}, 32'b0010);
        stay = 0;
        while (dig_sel === 4'b0010 && stay < 20) begin
            stay++;
            @(negedge clk);
        end
        checkOutput("scan_hold", stay, 4);
        checkOutput("scan_step2", {28'd0, dig_sel}, 32'b0100);
        checkDisplay({BL, BL, BL, BL}, "pre_conv");

        for (int v = 0; v < 13; v++) begin
            $display("[TB] vector %s", vecs[v].name);
            blank_lz = vecs[v].blz;
            applyStimulus(vecs[v].din, vecs[v].mode, 0, 1'b0);
            @(negedge clk);
            checkOutput({vecs[v].name, "_done_fall"}, {31'd0, bus.done}, 0);
            checkOutput({vecs[v].name, "_ovf"}, {31'd0, bus.ovf}, {31'd0, vecs[v].exp_ovf});
            checkDisplay(vecs[v].exp_seg, vecs[v].name);
        end

        $display("[TB] start ignored while busy");
        blank_lz = 1'b1;
        applyStimulus(16'd1234, 2'b01, 5, 1'b0);
        @(negedge clk);
        checkOutput("hs_done_fall", {31'd0, bus.done}, 0);
        stay = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) stay++;
            @(negedge clk);
        end
        checkOutput("hs_no_restart", stay, 0);
        checkDisplay({G1, G2, G3, G4}, "hs_first_result");

        $display("[TB] start accepted in done cycle");
        applyStimulus(16'd9, 2'b00, 0, 1'b0);
        applyStimulus(16'd7, 2'b00, 0, 1'b1);
        checkDisplay({BL, BL, BL, G7}, "done_cycle_start");

        $display("[TB] reset during conversion");
        @(negedge clk);
        bus.start = 1'b1;
        bus.din   = 16'd1234;
        bus.mode  = 2'b01;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("mid_busy_before", {31'd0, bus.busy}, 1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_busy", {31'd0, bus.busy}, 0);
        checkOutput("mid_rst_seg", {25'd0, seg}, 0);
        checkOutput("mid_rst_dig_sel", {28'd0, dig_sel}, 1);
        @(negedge clk);
        rst = 1'b0;
        stay = 0;
        for (int c = 0; c < 30; c++) begin
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) stay++;
            @(negedge clk);
        end
        checkOutput("post_rst_idle", stay, 0);
        checkOutput("post_rst_ovf", {31'd0, bus.ovf}, 0);
        checkDisplay({BL, BL, BL, BL}, "post_rst");
        applyStimulus(16'd1234, 2'b01, 0, 1'b0);
        checkDisplay({G1, G2, G3, G4}, "post_rst_conv");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
